timer_sequenciador: RTL and testbench

// - Top-level cooking sequencer for the keypad timer path.
// - Shifts digits from the keypad entry block (D/loadn) into a 4-digit BCD MM:SS register.
// - Owns the run/pause/done state machine and counts down on the 1 Hz tick.
// - Drives enablen back to the entry block: keypad is live only while idle.
// - Drives the magnetron enable and the done indication.

---
 rtl/timer_sequenciador.sv | 171 +++++++++++++++++
 tb/tb_timer_sequenciador.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_sequenciador.sv
// ---------------------------------------------------------------------------
// timer_sequenciador
// Cooking sequencer for the keypad timer path. Shifts keypad digits into a
// 4-digit BCD MM:SS register, runs the IDLE/COOKING/PAUSED/DONE machine and
// counts the time down on each 1 Hz tick.
//
// Ports
//   clk100       in   system clock, rising edge
//   clearn       in   asynchronous active-low reset
//   D[3:0]       in   BCD digit from the entry block, valid while loadn=0
//   loadn        in   active-low key-held strobe (falling edge = key)
//   pgt_1Hz      in   1 Hz square wave, rising edge = one tick
//   start        in   start button level
//   stop         in   stop/pause button level
//   cancel       in   cancel button level
//   door_closed  in   1 = door closed
//   min_bcd[7:0] out  {tens,units} minutes
//   sec_bcd[7:0] out  {tens,units} seconds
//   enablen      out  0 = keypad entry enabled (IDLE only)
//   magnetron_on out  1 only while COOKING
//   done         out  1 only while DONE
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | keypad live, digits shift in, waiting for start
// S_COOKING | magnetron on, one BCD decrement per tick
// S_PAUSED  | stopped or door opened, digits held, ticks ignored
// S_DONE    | time expired, done high until DONE_TICKS ticks or a key
// ---------------------------------------------------------------------------
module timer_sequenciador #(
  parameter int         DONE_TICKS   = 3,
  parameter logic [3:0] SEC_TENS_MAX = 4'd5
) (
  input  logic       clk100,
  input  logic       clearn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       start,
  input  logic       stop,
  input  logic       cancel,
  input  logic       door_closed,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       enablen,
  output logic       magnetron_on,
  output logic       done
);

  localparam int             CW       = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(DONE_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_COOKING, S_PAUSED, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_digits, w_digits_nxt, w_dec;   // {m1,m0,s1,s0}
  logic [CW-1:0] r_done_cnt, w_cnt_nxt;
  logic          r_loadn_q, r_start_q, r_stop_q, r_cancel_q, r_tick_q;

  logic w_ev_load, w_ev_start, w_ev_stop, w_ev_cancel, w_ev_tick, w_nonzero;

  assign w_ev_load   = r_loadn_q & ~loadn;
  assign w_ev_start  = start   & ~r_start_q;
  assign w_ev_stop   = stop    & ~r_stop_q;
  assign w_ev_cancel = cancel  & ~r_cancel_q;
  assign w_ev_tick   = pgt_1Hz & ~r_tick_q;
  assign w_nonzero   = (r_digits != 16'd0);

  // Per-digit BCD borrow ripple. Seconds-tens is not normalised, so a value
  // entered above SEC_TENS_MAX simply counts down from where it was keyed.
  always_comb begin
    w_dec = r_digits;
    if (r_digits[3:0] != 4'd0) begin
      w_dec[3:0] = r_digits[3:0] - 4'd1;
    end else if (r_digits[7:4] != 4'd0) begin
      w_dec[7:4] = r_digits[7:4] - 4'd1;
      w_dec[3:0] = 4'd9;
    end else if (r_digits[15:8] != 8'd0) begin
      if (r_digits[11:8] != 4'd0) begin
        w_dec[11:8] = r_digits[11:8] - 4'd1;
      end else begin
        w_dec[15:12] = r_digits[15:12] - 4'd1;
        w_dec[11:8]  = 4'd9;
      end
      w_dec[7:4] = SEC_TENS_MAX;
      w_dec[3:0] = 4'd9;
    end
  end

  always_ff @(posedge clk100 or negedge clearn) begin
    if (!clearn) begin
      r_state    <= S_IDLE;
      r_digits   <= 16'd0;
      r_done_cnt <= '0;
      r_loadn_q  <= 1'b1;
      r_start_q  <= 1'b0;
      r_stop_q   <= 1'b0;
      r_cancel_q <= 1'b0;
      r_tick_q   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_digits   <= w_digits_nxt;
      r_done_cnt <= w_cnt_nxt;
      r_loadn_q  <= loadn;
      r_start_q  <= start;
      r_stop_q   <= stop;
      r_cancel_q <= cancel;
      r_tick_q   <= pgt_1Hz;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_digits_nxt = r_digits;
    w_cnt_nxt    = r_done_cnt;
    if (w_ev_cancel) begin
      w_state_nxt  = S_IDLE;
      w_digits_nxt = 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // An accepted start consumes the cycle; a rejected one lets a key through.
          if (w_ev_start && door_closed && w_nonzero) begin
            w_state_nxt = S_COOKING;
          end else if (w_ev_load && (D <= 4'd9)) begin
            w_digits_nxt = {r_digits[11:0], D};
          end
        end
        S_COOKING: begin
          if (!door_closed || w_ev_stop) begin
            w_state_nxt = S_PAUSED;
          end else if (w_ev_tick) begin
            w_digits_nxt = w_dec;
            if (w_dec == 16'd0) begin
              w_state_nxt = S_DONE;
              w_cnt_nxt   = CNT_LOAD;
            end
          end
        end
        S_PAUSED: begin
          if (w_ev_stop) begin
            w_state_nxt  = S_IDLE;
            w_digits_nxt = 16'd0;
          end else if (w_ev_start && door_closed) begin
            w_state_nxt = S_COOKING;
          end
        end
        S_DONE: begin
          w_digits_nxt = 16'd0;
          if (w_ev_stop || w_ev_start || w_ev_load) begin
            w_state_nxt = S_IDLE;
          end else if (w_ev_tick) begin
            if (r_done_cnt == '0) w_state_nxt = S_IDLE;
            else                  w_cnt_nxt   = r_done_cnt - 1'b1;
          end
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_digits_nxt = 16'd0;
        end
      endcase
    end
  end

  assign min_bcd      = r_digits[15:8];
  assign sec_bcd      = r_digits[7:0];
  assign enablen      = (r_state != S_IDLE);
  assign magnetron_on = (r_state == S_COOKING);
  assign done         = (r_state == S_DONE);

endmodule

// File: tb/tb_timer_sequenciador.sv
module tb_timer_sequenciador;

  logic       clk100 = 1'b0;
  logic       clearn = 1'b0;
  logic [3:0] D = 4'd0;
  logic       loadn = 1'b1;
  logic       pgt_1Hz = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       cancel = 1'b0;
  logic       door_closed = 1'b1;
  logic [7:0] min_bcd, sec_bcd;
  logic       enablen, magnetron_on, done;

  int n_vec = 0;
  int n_err = 0;

  timer_sequenciador dut (
    .clk100(clk100), .clearn(clearn), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .start(start), .stop(stop), .cancel(cancel), .door_closed(door_closed),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .enablen(enablen),
    .magnetron_on(magnetron_on), .done(done)
  );

  always #5 clk100 = ~clk100;

  // Behavioural model: time held as a decimal MMSS integer, mode as a small
  // number (0 idle, 1 cooking, 2 paused, 3 done), done time as ticks left.
  localparam int MD_IDLE = 0, MD_COOK = 1, MD_PAUSE = 2, MD_DONE = 3;
  int m_time = 0;
  int m_mode = MD_IDLE;
  int m_left = 0;
  bit m_loadn_q = 1'b1, m_start_q = 1'b0, m_stop_q = 1'b0, m_cancel_q = 1'b0, m_tick_q = 1'b0;

  function automatic int dec_time(input int t);
    int mm, ss;
    mm = t / 100;
    ss = t % 100;
    if (ss > 0)       ss = ss - 1;
    else if (mm > 0) begin mm = mm - 1; ss = 59; end
    return mm * 100 + ss;
  endfunction

  task automatic model_step();
    bit e_load, e_start, e_stop, e_cancel, e_tick;
    if (!clearn) begin
      m_time = 0; m_mode = MD_IDLE; m_left = 0;
      m_loadn_q = 1'b1; m_start_q = 1'b0; m_stop_q = 1'b0; m_cancel_q = 1'b0; m_tick_q = 1'b0;
      return;
    end
    e_load   = m_loadn_q && !loadn;
    e_start  = start && !m_start_q;
    e_stop   = stop && !m_stop_q;
    e_cancel = cancel && !m_cancel_q;
    e_tick   = pgt_1Hz && !m_tick_q;
    m_loadn_q = loadn; m_start_q = start; m_stop_q = stop; m_cancel_q = cancel; m_tick_q = pgt_1Hz;
    if (e_cancel) begin
      m_time = 0; m_mode = MD_IDLE;
    end else if (m_mode == MD_IDLE) begin
      if (e_start && door_closed && m_time != 0) m_mode = MD_COOK;
      else if (e_load && D <= 9)               m_time = (m_time * 10 + int'(D)) % 10000;
    end else if (m_mode == MD_COOK) begin
      if (!door_closed || e_stop) m_mode = MD_PAUSE;
      else if (e_tick) begin
        m_time = dec_time(m_time);
        if (m_time == 0) begin m_mode = MD_DONE; m_left = 3; end
      end
    end else if (m_mode == MD_PAUSE) begin
      if (e_stop) begin m_time = 0; m_mode = MD_IDLE; end
      else if (e_start && door_closed) m_mode = MD_COOK;
    end else begin
      m_time = 0;
      if (e_stop || e_start || e_load) m_mode = MD_IDLE;
      else if (e_tick) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = MD_IDLE;
      end
    end
  endtask

  always @(posedge clk100 or negedge clearn) model_step();

  function automatic logic [7:0] bcd8(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare every output with the model.
  task automatic cyc();
    @(negedge clk100);
    chk("min_bcd", min_bcd, bcd8(m_time / 100));
    chk("sec_bcd", sec_bcd, bcd8(m_time % 100));
    chk("enablen", {7'd0, enablen}, {7'd0, m_mode != MD_IDLE});
    chk("magnetron_on", {7'd0, magnetron_on}, {7'd0, m_mode == MD_COOK});
    chk("done", {7'd0, done}, {7'd0, m_mode == MD_DONE});
  endtask

  task automatic key(input logic [3:0] d);
    D = d; loadn = 1'b0; cyc(); cyc();
    loadn = 1'b1; cyc();
  endtask

  task automatic btn(input int which);
    case (which)
      0: start = 1'b1;
      1: stop = 1'b1;
      2: cancel = 1'b1;
      default: pgt_1Hz = 1'b1;
    endcase
    cyc();
    start = 1'b0; stop = 1'b0; cancel = 1'b0; pgt_1Hz = 1'b0;
    cyc();
  endtask

  task automatic lit(input string nm, input logic [7:0] mn, input logic [7:0] sc,
                     input logic en, input logic mg, input logic dn);
    chk({nm, ".min"}, min_bcd, mn);
    chk({nm, ".sec"}, sec_bcd, sc);
    chk({nm, ".enablen"}, {7'd0, enablen}, {7'd0, en});
    chk({nm, ".magnetron"}, {7'd0, magnetron_on}, {7'd0, mg});
    chk({nm, ".done"}, {7'd0, done}, {7'd0, dn});
  endtask

  initial begin
    cyc();
    lit("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    clearn = 1'b1;
    cyc();

    key(4'd1); key(4'd3); key(4'd0);
    lit("keys130", 8'h01, 8'h30, 1'b0, 1'b0, 1'b0);
    key(4'd5);
    lit("key5", 8'h13, 8'h05, 1'b0, 1'b0, 1'b0);
    key(4'd12);
    lit("key_gt9", 8'h13, 8'h05, 1'b0, 1'b0, 1'b0);

    btn(2); key(4'd1); key(4'd0); key(4'd0);
    btn(0); btn(3);
    lit("cook_0059", 8'h00, 8'h59, 1'b1, 1'b1, 1'b0);
    btn(3);
    lit("cook_0058", 8'h00, 8'h58, 1'b1, 1'b1, 1'b0);

    btn(2); key(4'd4); key(4'd0); btn(0);
    door_closed = 1'b0; cyc(); cyc();
    lit("door_pause", 8'h00, 8'h40, 1'b1, 1'b0, 1'b0);
    btn(3); btn(3); btn(3);
    lit("pause_ticks", 8'h00, 8'h40, 1'b1, 1'b0, 1'b0);
    door_closed = 1'b1; cyc();
    btn(0); btn(3);
    lit("resume_0039", 8'h00, 8'h39, 1'b1, 1'b1, 1'b0);

    btn(2); key(4'd2); btn(0); btn(3); btn(3);
    lit("done_enter", 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    btn(3);
    lit("done_t1", 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    btn(3);
    lit("done_t2", 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    btn(3);
    lit("done_t3_idle", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    btn(0);
    lit("start_zero", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    key(4'd1); key(4'd0); btn(0);
    cancel = 1'b1; pgt_1Hz = 1'b1; cyc();
    cancel = 1'b0; pgt_1Hz = 1'b0; cyc();
    lit("cancel_tick", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    key(4'd1); key(4'd0); btn(0);
    stop = 1'b1; pgt_1Hz = 1'b1; cyc();
    stop = 1'b0; pgt_1Hz = 1'b0; cyc();
    lit("stop_tick", 8'h00, 8'h10, 1'b1, 1'b0, 1'b0);
    btn(1);
    lit("paused_stop", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    key(4'd9); key(4'd9); btn(0); btn(3);
    lit("sec99", 8'h00, 8'h98, 1'b1, 1'b1, 1'b0);
    btn(2); key(4'd1); key(4'd0); key(4'd0); key(4'd0); btn(0); btn(3);
    lit("borrow_1000", 8'h09, 8'h59, 1'b1, 1'b1, 1'b0);

    btn(2); key(4'd5); key(4'd1); key(4'd7); btn(0); btn(3);
    lit("pre_reset", 8'h05, 8'h16, 1'b1, 1'b1, 1'b0);
    #2 clearn = 1'b0;
    #1 lit("async_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc();
    clearn = 1'b1;
    cyc();

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) == 0) loadn = ~loadn;
      D       = 4'($urandom_range(15));
      start   = ($urandom_range(7) == 0);
      stop    = ($urandom_range(15) == 0);
      cancel  = ($urandom_range(59) == 0);
      if ($urandom_range(2) == 0) pgt_1Hz = ~pgt_1Hz;
      if ($urandom_range(49) == 0) door_closed = ~door_closed;
      cyc();
    end
    loadn = 1'b1; start = 1'b0; stop = 1'b0; cancel = 1'b0; pgt_1Hz = 1'b0; door_closed = 1'b1;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
